clk_div_monitor: RTL and testbench

- Downstream checker for the even-ratio clock divider output.
- Samples the divided clock as data in the source `clk` domain, detects its edges and measures every half-period in `clk` cycles.
- Flags ratio errors and stuck outputs, and reports lock once the divider toggles at the expected rate.
- Sits between the divider and any logic that needs a qualified divided-clock tick or health status.

---
 rtl/clk_div_mon_pkg.sv | 29 ++
 rtl/edge_sync_det.sv | 53 +++++
 rtl/clk_div_monitor.sv | 154 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_mon_pkg.sv
// Shared types and elaboration helpers for the divided-clock monitor.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } mon_state_e;

    // Run-counter value at which a missing edge is declared a stall.
    function automatic int unsigned timeout_thresh(input int unsigned exp_half,
                                                   input int unsigned tol);
        return 2 * exp_half + tol;
    endfunction

    function automatic int unsigned min_cnt_w(input int unsigned exp_half,
                                              input int unsigned tol);
        int unsigned need;
        int unsigned w;
        need = timeout_thresh(exp_half, tol);
        if (2 * exp_half + 1 > need) need = 2 * exp_half + 1;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if (((32'd1 << i) - 32'd1) < need) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Synchronises the divided clock as data and produces registered edge strobes.
module edge_sync_det #(
    parameter int unsigned SYNC_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic edge_o,
    output logic rise_o,
    output logic fall_o
);

    logic s_q;
    logic sd_q;
    logic rise_q;
    logic fall_q;

    if (SYNC_EN != 0) begin : g_sync2
        logic meta_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                meta_q <= 1'b0;
                s_q    <= 1'b0;
            end else begin
                meta_q <= d_i;
                s_q    <= meta_q;
            end
        end
    end else begin : g_sync1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) s_q <= 1'b0;
            else     s_q <= d_i;
        end
    end

    assign edge_o = s_q ^ sd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sd_q   <= s_q;
            rise_q <= edge_o & s_q;
            fall_q <= edge_o & ~s_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures half-periods of a divided clock, flags ratio errors and stalls, reports lock.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int unsigned EXP_HALF = 5,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned SYNC_EN  = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             err_clr,
    output logic             rise,
    output logic             fall,
    output logic             half_vld,
    output logic [CNT_W-1:0] half_len,
    output logic             err,
    output logic             err_sticky,
    output logic             stuck,
    output logic             locked
);

    localparam int unsigned GoodW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] ExpC    = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0] TolC    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] ThreshC = CNT_W'(timeout_thresh(EXP_HALF, TOL));

    if (CNT_W < min_cnt_w(EXP_HALF, TOL)) begin : g_cnt_w_check
        $error("clk_div_monitor: CNT_W too small for EXP_HALF/TOL");
    end

    logic             edge_det;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    mon_state_e       state_q, state_d;
    logic [GoodW-1:0] good_q, good_d, good_inc;
    logic             half_vld_q, half_vld_d;
    logic [CNT_W-1:0] half_len_q, half_len_d;
    logic             err_q, err_d;
    logic             stuck_q, stuck_d;
    logic             err_sticky_q, err_sticky_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] diff;
    logic             good_half;
    logic             timeout;

    edge_sync_det #(
        .SYNC_EN(SYNC_EN)
    ) u_edge (
        .clk   (clk),
        .rst   (rst),
        .d_i   (clk_in),
        .edge_o(edge_det),
        .rise_o(rise),
        .fall_o(fall)
    );

    always_comb begin
        diff      = (cnt_q > ExpC) ? (cnt_q - ExpC) : (ExpC - cnt_q);
        good_half = (diff <= TolC);
        timeout   = armed_q && !edge_det && (cnt_q == ThreshC);
        good_inc  = good_q + 1'b1;

        // Counter restarts at 1 so that at the next edge it equals the cycles elapsed.
        if (edge_det)    cnt_d = CNT_W'(1);
        else if (&cnt_q) cnt_d = cnt_q;
        else             cnt_d = cnt_q + 1'b1;

        armed_d    = edge_det ? 1'b1 : (timeout ? 1'b0 : armed_q);
        state_d    = state_q;
        good_d     = good_q;
        half_vld_d = 1'b0;
        half_len_d = half_len_q;
        err_d      = 1'b0;
        stuck_d    = 1'b0;

        if (edge_det) begin
            case (state_q)
                IDLE: begin
                    good_d  = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    half_vld_d = 1'b1;
                    half_len_d = cnt_q;
                    if (good_half) begin
                        good_d = good_inc;
                        if (good_inc == GoodW'(LOCK_CNT)) state_d = LOCK;
                    end else begin
                        err_d  = 1'b1;
                        good_d = '0;
                    end
                end
                LOCK: begin
                    half_vld_d = 1'b1;
                    half_len_d = cnt_q;
                    if (!good_half) begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = ACQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            stuck_d = 1'b1;
            good_d  = '0;
            state_d = IDLE;
        end

        locked_d = (state_d == LOCK);

        // A fresh error outranks a simultaneous clear.
        if (err_q || stuck_q) err_sticky_d = 1'b1;
        else if (err_clr)     err_sticky_d = 1'b0;
        else                  err_sticky_d = err_sticky_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            good_q       <= '0;
            half_vld_q   <= 1'b0;
            half_len_q   <= '0;
            err_q        <= 1'b0;
            stuck_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            good_q       <= good_d;
            half_vld_q   <= half_vld_d;
            half_len_q   <= half_len_d;
            err_q        <= err_d;
            stuck_q      <= stuck_d;
            err_sticky_q <= err_sticky_d;
            locked_q     <= locked_d;
        end
    end

    assign half_vld   = half_vld_q;
    assign half_len   = half_len_q;
    assign err        = err_q;
    assign stuck      = stuck_q;
    assign err_sticky = err_sticky_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench: two monitors (TOL=0/2-flop sync, TOL=1/1-flop sync) on one stimulus.
module tb_clk_div_monitor;
    import clk_div_mon_pkg::*;

    logic clk = 1'b0;
    logic rst, clk_in, err_clr;

    logic rise0, fall0, half_vld0, err0, err_sticky0, stuck0, locked0;
    logic [7:0] half_len0;
    logic rise1, fall1, half_vld1, err1, err_sticky1, stuck1, locked1;
    logic [7:0] half_len1;

    clk_div_monitor u_dut0 (
        .clk(clk), .rst(rst), .clk_in(clk_in), .err_clr(err_clr),
        .rise(rise0), .fall(fall0), .half_vld(half_vld0), .half_len(half_len0),
        .err(err0), .err_sticky(err_sticky0), .stuck(stuck0), .locked(locked0)
    );

    clk_div_monitor #(.TOL(1), .SYNC_EN(0)) u_dut1 (
        .clk(clk), .rst(rst), .clk_in(clk_in), .err_clr(err_clr),
        .rise(rise1), .fall(fall1), .half_vld(half_vld1), .half_len(half_len1),
        .err(err1), .err_sticky(err_sticky1), .stuck(stuck1), .locked(locked1)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int n_vld0 = 0, n_err0 = 0, n_stuck0 = 0, n_rise0 = 0, n_fall0 = 0, n_badlen0 = 0;
    int n_err_drop0 = 0, vld_at_lock0 = 0, last_edge_cyc = 0, stuck_cyc = 0;
    int n_vld1 = 0, n_err1 = 0, vld_at_lock1 = 0;
    logic [7:0] exp_len = 8'd5, last_len0 = 8'd0;
    logic prev_locked0 = 1'b0, prev_locked1 = 1'b0;

    // Event tallies sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (half_vld0) begin
            n_vld0++;
            last_len0 = half_len0;
            if (half_len0 != exp_len) n_badlen0++;
        end
        if (err0) begin
            n_err0++;
            if (prev_locked0 && !locked0) n_err_drop0++;
        end
        if (stuck0) begin
            n_stuck0++;
            stuck_cyc = cyc;
        end
        if (rise0) n_rise0++;
        if (fall0) n_fall0++;
        if (rise0 || fall0) last_edge_cyc = cyc;
        if (locked0 && !prev_locked0) vld_at_lock0 = n_vld0;
        prev_locked0 = locked0;
        if (half_vld1) n_vld1++;
        if (err1) n_err1++;
        if (locked1 && !prev_locked1) vld_at_lock1 = n_vld1;
        prev_locked1 = locked1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_stats();
        n_vld0 = 0; n_err0 = 0; n_stuck0 = 0; n_rise0 = 0; n_fall0 = 0; n_badlen0 = 0;
        n_err_drop0 = 0; vld_at_lock0 = 0; n_vld1 = 0; n_err1 = 0; vld_at_lock1 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_in = 1'b0; err_clr = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        clr_stats();
    endtask

    // Toggle clk_in n times, holding each level h clk cycles.
    task automatic toggles(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            clk_in = ~clk_in;
            step(h);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_in = 1'b0; err_clr = 1'b0;
        step(2);
        n_tests++;
        if ({rise0, fall0, half_vld0, half_len0, err0, err_sticky0, stuck0, locked0} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outs0: got %h expected 0",
                     {rise0, fall0, half_vld0, half_len0, err0, err_sticky0, stuck0, locked0});
        end
        n_tests++;
        if ({rise1, fall1, half_vld1, half_len1, err1, err_sticky1, stuck1, locked1} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outs1: got %h expected 0",
                     {rise1, fall1, half_vld1, half_len1, err1, err_sticky1, stuck1, locked1});
        end
        n_tests++;
        if (u_dut0.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", u_dut0.state_q, IDLE);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_latency();
        do_reset();
        clk_in = 1'b1;
        step(2);
        n_tests++;
        if ({rise0, rise1} !== 2'b01) begin
            n_fail++;
            $display("FAIL latency_2cyc: got %b expected 01", {rise0, rise1});
        end
        step(1);
        n_tests++;
        if ({rise0, rise1} !== 2'b10) begin
            n_fail++;
            $display("FAIL latency_3cyc: got %b expected 10", {rise0, rise1});
        end
        clk_in = 1'b0;
        step(3);
        n_tests++;
        if ({fall0, rise0} !== 2'b10) begin
            n_fail++;
            $display("FAIL latency_fall: got %b expected 10", {fall0, rise0});
        end
    endtask

    task automatic test_lock();
        do_reset();
        exp_len = 8'd5;
        toggles(5, 12);
        n_tests++;
        if (n_vld0 != 11) begin n_fail++; $display("FAIL lock_vld_count: got %0d expected 11", n_vld0); end
        n_tests++;
        if (vld_at_lock0 != 4) begin n_fail++; $display("FAIL lock_at_4th: got %0d expected 4", vld_at_lock0); end
        n_tests++;
        if (n_err0 != 0) begin n_fail++; $display("FAIL lock_no_err: got %0d expected 0", n_err0); end
        n_tests++;
        if (n_badlen0 != 0) begin n_fail++; $display("FAIL lock_len5: got %0d bad expected 0", n_badlen0); end
        n_tests++;
        if (locked0 !== 1'b1) begin n_fail++; $display("FAIL lock_level: got %b expected 1", locked0); end
        n_tests++;
        if (n_rise0 != 6 || n_fall0 != 6) begin
            n_fail++;
            $display("FAIL lock_edges: got %0d/%0d expected 6/6", n_rise0, n_fall0);
        end
    endtask

    task automatic test_ratio_err();
        do_reset();
        toggles(5, 5);
        n_tests++;
        if (locked0 !== 1'b1) begin n_fail++; $display("FAIL ratio_prelock: got %b expected 1", locked0); end
        toggles(6, 3);
        n_tests++;
        if (n_vld0 != 7) begin n_fail++; $display("FAIL ratio_vld: got %0d expected 7", n_vld0); end
        n_tests++;
        if (n_err0 != 2) begin n_fail++; $display("FAIL ratio_err_count: got %0d expected 2", n_err0); end
        n_tests++;
        if (n_err_drop0 != 1) begin
            n_fail++;
            $display("FAIL ratio_lock_drop: got %0d expected 1", n_err_drop0);
        end
        n_tests++;
        if (last_len0 !== 8'd6) begin n_fail++; $display("FAIL ratio_len: got %0d expected 6", last_len0); end
        n_tests++;
        if ({locked0, err_sticky0} !== 2'b01) begin
            n_fail++;
            $display("FAIL ratio_lock_sticky: got %b expected 01", {locked0, err_sticky0});
        end
        n_tests++;
        if (n_err1 != 0 || locked1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ratio_tol1: got err=%0d locked=%b expected 0/1", n_err1, locked1);
        end
    endtask

    task automatic test_err_clr();
        bit found;
        do_reset();
        toggles(5, 5);
        step(1);
        clk_in = ~clk_in;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            if (err0) found = 1'b1;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL clr_err_seen: got 0 expected 1"); end
        err_clr = 1'b1;
        step(1);
        n_tests++;
        if (err_sticky0 !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_set_wins: got %b expected 1", err_sticky0);
        end
        step(1);
        n_tests++;
        if (err_sticky0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_clears: got %b expected 0", err_sticky0);
        end
        err_clr = 1'b0;
    endtask

    task automatic test_stuck();
        do_reset();
        exp_len = 8'd5;
        toggles(5, 6);
        n_tests++;
        if (locked0 !== 1'b1) begin n_fail++; $display("FAIL stuck_prelock: got %b expected 1", locked0); end
        step(20);
        n_tests++;
        if (n_stuck0 != 1) begin n_fail++; $display("FAIL stuck_once: got %0d expected 1", n_stuck0); end
        n_tests++;
        if (stuck_cyc - last_edge_cyc != 10) begin
            n_fail++;
            $display("FAIL stuck_delay: got %0d expected 10", stuck_cyc - last_edge_cyc);
        end
        n_tests++;
        if ({locked0, err_sticky0} !== 2'b01) begin
            n_fail++;
            $display("FAIL stuck_flags: got %b expected 01", {locked0, err_sticky0});
        end
        n_tests++;
        if (u_dut0.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL stuck_state: got %0d expected %0d", u_dut0.state_q, IDLE);
        end
        step(300);
        n_tests++;
        if (n_stuck0 != 1) begin n_fail++; $display("FAIL stuck_no_repeat: got %0d expected 1", n_stuck0); end
        clr_stats();
        toggles(5, 7);
        n_tests++;
        if (n_vld0 != 6 || vld_at_lock0 != 4) begin
            n_fail++;
            $display("FAIL stuck_reacq: got vld=%0d at_lock=%0d expected 6/4", n_vld0, vld_at_lock0);
        end
        n_tests++;
        if (n_err0 != 0 || locked0 !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_relock: got err=%0d locked=%b expected 0/1", n_err0, locked0);
        end
    endtask

    task automatic test_tol();
        do_reset();
        toggles(6, 6);
        n_tests++;
        if (n_vld1 != 5 || vld_at_lock1 != 4) begin
            n_fail++;
            $display("FAIL tol1_lock: got vld=%0d at_lock=%0d expected 5/4", n_vld1, vld_at_lock1);
        end
        n_tests++;
        if (n_err1 != 0 || locked1 !== 1'b1) begin
            n_fail++;
            $display("FAIL tol1_status: got err=%0d locked=%b expected 0/1", n_err1, locked1);
        end
        n_tests++;
        if (n_err0 != 5 || locked0 !== 1'b0) begin
            n_fail++;
            $display("FAIL tol0_errs: got err=%0d locked=%b expected 5/0", n_err0, locked0);
        end
        n_tests++;
        if (last_len0 !== 8'd6) begin n_fail++; $display("FAIL tol0_len: got %0d expected 6", last_len0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        toggles(5, 6);
        n_tests++;
        if (locked0 !== 1'b1) begin n_fail++; $display("FAIL arst_prelock: got %b expected 1", locked0); end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({locked0, half_len0, err_sticky0} !== 10'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: got %h expected 0", {locked0, half_len0, err_sticky0});
        end
        #1 rst = 1'b0;
        step(2);
        clr_stats();
        toggles(5, 3);
        n_tests++;
        if (n_vld0 != 2) begin n_fail++; $display("FAIL arst_partial: got %0d expected 2", n_vld0); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_lock();
        test_ratio_err();
        test_err_clr();
        test_stuck();
        test_tol();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
